imem_line_loader: RTL

IMEM_LINE_LOADER -- requirements
Module: imem_line_loader

---
 rtl/imem_line_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_line_loader.sv
// rtl/imem_line_loader.sv - streams slot words into instruction-memory lines and writes each full line
module imem_line_loader #(
  parameter int WORD_W = 48,
  parameter int SLOTS  = 5,
  parameter int ADDR_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           line_count,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_word,
  output logic                      in_ready,
  output logic                      WEPin,
  output logic [ADDR_W-1:0]         WEAddress,
  output logic [WORD_W*SLOTS-1:0]   idataWrite,
  output logic                      busy,
  output logic                      done
);

  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  // Reset asserts immediately but releases two edges later, away from any input activity.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t                    state_q;
  logic [SLOT_W-1:0]         slot_q;
  logic [ADDR_W:0]           remaining_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [WORD_W*SLOTS-1:0]   line_q;
  logic [WORD_W*SLOTS-1:0]   line_d;
  logic                      in_ready_q;
  logic                      wep_q;
  logic                      busy_q;
  logic                      done_q;
  logic [ADDR_W-1:0]         waddr_q;
  logic [WORD_W*SLOTS-1:0]   wdata_q;

  always_comb begin
    line_d = line_q;
    line_d[int'(slot_q)*WORD_W +: WORD_W] = in_word;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      in_ready_q  <= 1'b0;
      wep_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (line_count != '0) begin
              state_q     <= FILL;
              addr_q      <= base_addr;
              remaining_q <= line_count;
              slot_q      <= '0;
              in_ready_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (abort) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (in_valid) begin
            line_q <= line_d;
            if (slot_q == LAST_SLOT) begin
              // The final word goes straight into the write data so WEPin follows it by one cycle.
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              wep_q      <= 1'b1;
              waddr_q    <= addr_q;
              wdata_q    <= line_d;
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
            end
          end
        end
        WRITE: begin
          wep_q       <= 1'b0;
          remaining_q <= remaining_q - (ADDR_W+1)'(1);
          slot_q      <= '0;
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (remaining_q == (ADDR_W+1)'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= FILL;
            addr_q     <= addr_q + ADDR_W'(1);
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign WEPin      = wep_q;
  assign WEAddress  = waddr_q;
  assign idataWrite = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
